mem_arbiter: RTL and testbench

Two-port memory arbiter and access sequencer between the microcoded core and a single shared memory. It arbitrates round-robin between the instruction-fetch port and the data port and drives the memory through a fixed-latency access. It returns a one-cycle ready pulse that serves as the core's MEM_R stall release. It also performs byte-lane steering for byte, halfword and word data accesses.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_lane_align.sv | 51 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arbState_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering: byte enables and store replication towards memory,
// zero-extended right-aligned extraction of load data from memory.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0] byteLane;

    always_comb begin
        byteLane = rdata_i[7:0];
        case (addrLo_i)
            2'd0:    byteLane = rdata_i[7:0];
            2'd1:    byteLane = rdata_i[15:8];
            2'd2:    byteLane = rdata_i[23:16];
            default: byteLane = rdata_i[31:24];
        endcase
    end

    // Size 2'b11 falls into the word path along with SZ_WORD.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addrLo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, byteLane};
            end
            SZ_HALF: begin
                be_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, (addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0])};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the fetch and data ports of the core, driving
// one shared memory through a fixed-latency access with a one-cycle ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    arbState_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lastGrant_q, lastGrant_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       fRdata_q, fRdata_d;
    logic [31:0]       dRdata_q, dRdata_d;

    logic              pickD;
    logic              busy;
    logic [3:0]        laneBe;
    logic [31:0]       laneWdata;
    logic [31:0]       laneRdata;

    // On a tie the port that was not served last wins.
    assign pickD = (f_req && d_req) ? (lastGrant_q == GNT_F) : d_req;
    assign busy  = (state_q == BUSY);

    mem_lane_align u_laneAlign (
        .size_i   (size_q),
        .addrLo_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .be_o     (laneBe),
        .wdata_o  (laneWdata),
        .rdata_o  (laneRdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        fRdata_d    = fRdata_q;
        dRdata_d    = dRdata_q;
        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    state_d = BUSY;
                    if (pickD) begin
                        grant_d = GNT_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        size_d  = d_size;
                        wdata_d = d_wdata;
                    end else begin
                        grant_d = GNT_F;
                        addr_d  = f_addr;
                        we_d    = 1'b0;
                        size_d  = SZ_WORD;
                        wdata_d = 32'h0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (grant_q == GNT_F) begin
                        fRdata_d = laneRdata;
                    end else begin
                        dRdata_d = we_q ? 32'h0 : laneRdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                lastGrant_d = grant_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset favours fetch on the first tie by pretending data was served last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lastGrant_q <= GNT_D;
            grant_q     <= GNT_F;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            wdata_q     <= 32'h0;
            fRdata_q    <= 32'h0;
            dRdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            fRdata_q    <= fRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    assign f_ready   = (state_q == DONE) && (grant_q == GNT_F);
    assign d_ready   = (state_q == DONE) && (grant_q == GNT_D);
    assign f_rdata   = fRdata_q;
    assign d_rdata   = dRdata_q;

    assign mem_en    = busy;
    assign mem_we    = busy && we_q;
    assign mem_be    = busy ? laneBe : 4'b0000;
    assign mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = busy ? laneWdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level arbitration and memory
// model predicts accesses and responses; a monitor checks them as they appear.
module tb_mem_arbiter;

    localparam int WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [31:0] f_rdata, d_rdata;
    logic        f_ready, d_ready;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(32), .WAIT_CYCLES(WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_ready   (f_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } portExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } memExp_t;

    portExp_t    fExpQ[$];
    portExp_t    dExpQ[$];
    memExp_t     memExpQ[$];
    logic [31:0] refMem [256];
    logic [31:0] memArr [256];
    bit          mLastD;
    bit          abortBusy = 1'b0;

    logic [31:0] sFAddr, sDAddr, sDWdata;
    logic        sDWe;
    logic [1:0]  sDSize;

    function automatic logic [31:0] initWord(int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
        if (i == 32'h100 / 4) w = 32'hE3A01005;
        if (i == 32'h204 / 4) w = 32'h1234ABCD;
        return w;
    endfunction

    // Bench-side memory: combinational read, byte-enabled write sampled mid-cycle.
    assign mem_rdata = mem_en ? memArr[mem_addr[9:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = initWord(i);
        forever begin
            @(negedge clk);
            if (mem_en && mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) memArr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference for one granted access: memory-side view plus port response.
    task automatic modelPort(bit isD, int readyCyc);
        memExp_t     m;
        portExp_t    p;
        int          idx;
        int          lane;
        logic [31:0] word;
        p.cyc = readyCyc;
        if (!isD) begin
            m.addr  = sFAddr & ~32'h3;
            m.be    = 4'hF;
            m.wdata = 32'h0;
            m.we    = 1'b0;
            p.data  = refMem[sFAddr[9:2]];
            memExpQ.push_back(m);
            fExpQ.push_back(p);
        end else begin
            idx    = int'(sDAddr[9:2]);
            lane   = int'(sDAddr[1:0]);
            word   = refMem[idx];
            m.addr = sDAddr & ~32'h3;
            m.we   = sDWe;
            case (sDSize)
                2'b00: begin
                    m.be    = 4'(1 << lane);
                    m.wdata = (sDWdata & 32'hFF) * 32'h01010101;
                    p.data  = (word >> (8 * lane)) & 32'hFF;
                end
                2'b01: begin
                    m.be    = (lane >= 2) ? 4'hC : 4'h3;
                    m.wdata = (sDWdata & 32'hFFFF) * 32'h00010001;
                    p.data  = (word >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
                end
                default: begin
                    m.be    = 4'hF;
                    m.wdata = sDWdata;
                    p.data  = word;
                end
            endcase
            if (sDWe) begin
                for (int b = 0; b < 4; b++)
                    if (m.be[b]) word[8*b +: 8] = m.wdata[8*b +: 8];
                refMem[idx] = word;
                p.data = 32'h0;
            end
            memExpQ.push_back(m);
            dExpQ.push_back(p);
        end
    endtask

    // Round-robin at transaction level: each grant costs WAIT+2 cycles.
    task automatic predict(int nF, int nD, int s);
        int t  = s;
        int rf = nF;
        int rd = nD;
        bit pickD;
        while (rf > 0 || rd > 0) begin
            if (rf > 0 && rd > 0) pickD = !mLastD;
            else                  pickD = (rd > 0);
            modelPort(pickD, t + WAIT + 1);
            t      = t + WAIT + 2;
            mLastD = pickD;
            if (pickD) rd--;
            else       rf--;
        end
    endtask

    task automatic applyStimulus(int nF, int nD, bit scramble, bit dropEarly);
        int s     = cyc;
        int remF  = nF;
        int remD  = nD;
        int guard = 0;
        int limit = (nF + nD) * (WAIT + 2) + 10;
        f_addr  = sFAddr;
        d_addr  = sDAddr;
        d_we    = sDWe;
        d_size  = sDSize;
        d_wdata = sDWdata;
        f_req   = (nF > 0);
        d_req   = (nD > 0);
        predict(nF, nD, s);
        if (scramble || dropEarly) begin
            @(posedge clk); #1;
            if (scramble) begin
                f_addr  = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 1'($urandom);
                d_size  = 2'($urandom);
            end
            if (dropEarly) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end
        while ((remF > 0 || remD > 0) && guard < limit) begin
            @(negedge clk);
            if (f_ready) remF--;
            if (d_ready) remD--;
            @(posedge clk); #1;
            if (remF <= 0) f_req = 1'b0;
            if (remD <= 0) d_req = 1'b0;
            guard++;
        end
        checkOutput("handshake_done", 32'(remF <= 0 && remD <= 0), 32'd1);
        f_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        mLastD = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT completes or touches memory.
    initial begin
        memExp_t  cur;
        portExp_t p;
        int       busyLen = 0;
        bit       prevEn  = 1'b0;
        cur = '{addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0};
        forever begin
            @(negedge clk);
            if (f_ready || d_ready)
                checkOutput("ready_exclusive", 32'(f_ready && d_ready), 32'd0);
            if (f_ready) begin
                if (fExpQ.size() == 0) checkOutput("f_ready_unexpected", 32'd1, 32'd0);
                else begin
                    p = fExpQ.pop_front();
                    checkOutput("f_rdata", f_rdata, p.data);
                    checkOutput("f_ready_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            if (d_ready) begin
                if (dExpQ.size() == 0) checkOutput("d_ready_unexpected", 32'd1, 32'd0);
                else begin
                    p = dExpQ.pop_front();
                    checkOutput("d_rdata", d_rdata, p.data);
                    checkOutput("d_ready_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            if (mem_en) begin
                if (!prevEn) begin
                    busyLen = 0;
                    if (memExpQ.size() == 0) checkOutput("mem_en_unexpected", 32'd1, 32'd0);
                    else cur = memExpQ.pop_front();
                end
                busyLen++;
                checkOutput("mem_addr", mem_addr, cur.addr);
                checkOutput("mem_be", 32'(mem_be), 32'(cur.be));
                checkOutput("mem_wdata", mem_wdata, cur.wdata);
                checkOutput("mem_we", 32'(mem_we), 32'(cur.we));
            end else begin
                if (prevEn) begin
                    if (!abortBusy) checkOutput("busy_length", 32'(busyLen), 32'(WAIT));
                    abortBusy = 1'b0;
                end
                checkOutput("mem_idle_zero", mem_addr | mem_wdata | {27'h0, mem_be, mem_we}, 32'h0);
            end
            prevEn = mem_en;
        end
    end

    initial begin
        int mode;
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
        f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        sFAddr = 32'h0; sDAddr = 32'h0; sDWdata = 32'h0; sDWe = 1'b0; sDSize = 2'b10;
        mLastD = 1'b1;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_f_ready", 32'(f_ready), 32'd0);
        checkOutput("reset_d_ready", 32'(d_ready), 32'd0);
        checkOutput("reset_f_rdata", f_rdata, 32'h0);
        checkOutput("reset_d_rdata", d_rdata, 32'h0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] fetch of 0x103");
        sFAddr = 32'h103;
        applyStimulus(1, 0, 1'b0, 1'b0);

        $display("[TB] both ports held from reset");
        doReset();
        sFAddr = 32'h40; sDAddr = 32'h80; sDWe = 1'b0; sDSize = 2'b10;
        applyStimulus(2, 2, 1'b0, 1'b0);

        $display("[TB] byte store then byte load at 0x202");
        sDAddr = 32'h202; sDWdata = 32'h000000AB; sDWe = 1'b1; sDSize = 2'b00;
        applyStimulus(0, 1, 1'b1, 1'b0);
        sDWe = 1'b0; sDWdata = 32'h0;
        applyStimulus(0, 1, 1'b0, 1'b0);

        $display("[TB] half load at 0x206");
        sDAddr = 32'h206; sDSize = 2'b01;
        applyStimulus(0, 1, 1'b0, 1'b0);

        $display("[TB] data request dropped after the idle sample");
        sDAddr = 32'h300; sDSize = 2'b10;
        applyStimulus(0, 1, 1'b0, 1'b1);

        $display("[TB] reset during the second busy cycle");
        sFAddr = 32'h104;
        applyStimulus(1, 0, 1'b0, 1'b0);
        sFAddr = 32'h3F0;
        f_addr = sFAddr;
        f_req  = 1'b1;
        predict(1, 0, cyc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; f_req = 1'b0; abortBusy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fExpQ.delete();
        mLastD = 1'b1;
        @(negedge clk);
        checkOutput("mem_en_after_reset", 32'(mem_en), 32'd0);
        checkOutput("ready_after_reset", 32'({f_ready, d_ready}), 32'd0);
        @(posedge clk); #1;
        sFAddr = 32'h10; sDAddr = 32'h20; sDWe = 1'b0; sDSize = 2'b10;
        applyStimulus(1, 1, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            mode    = int'($urandom_range(0, 3));
            sFAddr  = 32'($urandom_range(0, 1023));
            sDAddr  = 32'($urandom_range(0, 1023));
            sDWdata = $urandom;
            sDWe    = 1'($urandom);
            sDSize  = 2'($urandom);
            case (mode)
                0:       applyStimulus(1, 0, 1'($urandom), 1'($urandom));
                1:       applyStimulus(0, 1, 1'($urandom), 1'($urandom));
                2:       applyStimulus(1, 1, 1'b0, 1'b0);
                default: applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1'b0, 1'b0);
            endcase
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("f_queue_drained", 32'(fExpQ.size()), 32'd0);
        checkOutput("d_queue_drained", 32'(dExpQ.size()), 32'd0);
        checkOutput("mem_queue_drained", 32'(memExpQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
